mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (combinational read, clocked write, memRead/memWr strobes).
- Port 0 is the CPU load/store unit; port 1 is the program loader/DMA.
- Round-robin grant, registered request capture and a registered response, so neither requester touches the memory strobes directly.

Parameters:
- N, 64, data and address width.
- LOG2SIZE, 10, memory index width.
- SIZE, 1024, memory depth in words.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_0, req_1  input  1  transaction request, held until ack.
- we_0, we_1  input  1  1 = write, 0 = read; held with req.
- addr_0, addr_1  input  N  word address; held with req.
- wdata_0, wdata_1  input  N  write data; held with req.
- ack_0, ack_1  output  1  one-cycle accept pulse (combinational from state + req).
- rsp_0, rsp_1  output  1  one-cycle completion pulse.
- rdata_0, rdata_1  output  N  read data, valid when rsp_i is high for a read.
- mem_addr  output  N  to memory Address.
- mem_din  output  N  to memory DataIn.
- mem_rd  output  1  to memory memRead.
- mem_wr  output  1  to memory memWr.
- mem_dout  input  N  from memory DataOut.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All ack/rsp/mem_rd/mem_wr = 0; rdata_*, mem_addr, mem_din, latched fields = 0.
- FSM states: IDLE, ISSUE.
- IDLE:
  - Winner: sole requester if only one req_i is high; if both, the port != last_grant.
  - ack_winner = 1 this cycle. On the clock edge, latch port id, we, addr, wdata; last_grant <= winner; go to ISSUE.
  - No req: stay in IDLE.
  - ack is never asserted outside IDLE.
- ISSUE (exactly one cycle):
  - mem_addr = latched addr; mem_din = latched wdata.
  - mem_rd = ~we, mem_wr = we. All are decoded from registers, so they are glitch-free.
  - On the edge: the memory commits a write; the arbiter captures mem_dout into rdata_<port> for a read; rsp_<port> <= 1; go to IDLE.
- Response cycle:
  - rsp_i is high for one cycle, coincident with IDLE, so a new accept can happen in the same cycle.
  - Throughput: 1 transaction per 2 cycles.
  - Latency: accept at cycle T, memory access at T+1, rsp at T+2.
- rdata_i holds its last read value until the next read completion on that port; writes do not alter rdata_i.
- Outside ISSUE: mem_rd = mem_wr = 0, mem_addr/mem_din hold their last value.
- Address width rule: the memory indexes with addr[LOG2SIZE-1:0]; upper bits are passed through unmodified unless the optional feature is enabled.
- Boundary conditions:
  - Both ports request continuously: grants strictly alternate 0,1,0,1.
  - A port that drops req before ack is simply not served; no error.
  - Same port requests back-to-back: it may be re-granted only if the other port is idle.
  - Read-after-write to the same address from either port returns the new data (the write commits before the next ISSUE).
- Reset mid-operation:
  - Reset during ISSUE deasserts mem_wr asynchronously. A write whose commit edge coincides with or follows reset assertion is dropped.
  - A pending rsp is lost; requesters must re-issue after reset.

Optional Feature:
- Macro: MEM_ARB_BOUNDS_CHECK_EN.
- Enabled:
  - Adds outputs err_0, err_1 (1 bit each).
  - An accepted transaction with addr >= SIZE runs ISSUE with mem_rd = mem_wr = 0 (write suppressed).
  - It completes with rsp_i and err_i = 1 for one cycle; rdata_i = 0 for reads.
- Disabled:
  - No err ports; all addresses are issued and the memory truncates them to LOG2SIZE bits.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE}.
  - Port id constants PORT_CPU=0, PORT_DMA=1.
  - Default width constants N=64, LOG2SIZE=10.
- Sub-module rr_arbiter2: purely combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_id.
- The FSM and the registers stay in mem_arbiter.

Test Plan:
- Port 0 writes 0xDEAD_BEEF to addr 5; port 0 later reads addr 5. Required: ack_0 at T, mem_wr=1 at T+1, rsp_0 at T+2; the read returns rdata_0 = 0xDEAD_BEEF at its T+2.
- req_0 and req_1 held high for 8 cycles after reset, all reads. Required: ack order 0,1,0,1; 4 accepts total; each rsp goes only to its own port.
- Port 1 writes 0x1234 to addr 9; port 0 read of addr 9 is pending during that write's ISSUE. Required: the port 0 read returns 0x1234.
- Reset asserted mid-ISSUE of a write of 0xFF to addr 3. Required: mem_wr drops immediately, addr 3 unchanged, no rsp; next tie goes to port 0.
- With MEM_ARB_BOUNDS_CHECK_EN, port 1 writes addr 1024. Required: mem_wr stays 0, rsp_1 = err_1 = 1 at T+2. Without the macro: mem_wr=1 and addr 0 is written.
- Port 0 raises req for 1 cycle while port 1 holds priority. Required: no ack_0, no rsp_0, no hang; the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
// Optional bounds checking is enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
package mem_arb_pkg;
  localparam int N        = 64;
  localparam int LOG2SIZE = 10;
  localparam int SIZE     = 1 << LOG2SIZE;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic {IDLE, ISSUE} stateT;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle for mem_arbiter; err_0/err_1 exist only
// when MEM_ARB_BOUNDS_CHECK_EN is defined.
interface mem_arbiter_if #(parameter int N = mem_arb_pkg::N);
  logic         req_0, req_1;
  logic         we_0, we_1;
  logic [N-1:0] addr_0, addr_1;
  logic [N-1:0] wdata_0, wdata_1;
  logic         ack_0, ack_1;
  logic         rsp_0, rsp_1;
  logic [N-1:0] rdata_0, rdata_1;
  logic [N-1:0] mem_addr, mem_din, mem_dout;
  logic         mem_rd, mem_wr;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic         err_0, err_1;

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    output ack_0, ack_1, rsp_0, rsp_1, rdata_0, rdata_1,
           mem_addr, mem_din, mem_rd, mem_wr, err_0, err_1
  );
  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    input  ack_0, ack_1, rsp_0, rsp_1, rdata_0, rdata_1,
           mem_addr, mem_din, mem_rd, mem_wr, err_0, err_1
  );
`else
  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    output ack_0, ack_1, rsp_0, rsp_1, rdata_0, rdata_1,
           mem_addr, mem_din, mem_rd, mem_wr
  );
  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    input  ack_0, ack_1, rsp_0, rsp_1, rdata_0, rdata_1,
           mem_addr, mem_din, mem_rd, mem_wr
  );
`endif
endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational two-way round-robin pick: on a tie the port that did not
// win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  always_comb begin
    grant_valid = |req;
    if (&req) grant_id = ~last_grant;
    else      grant_id = req[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Define MEM_ARB_BOUNDS_CHECK_EN to reject addresses >= SIZE with err_i.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N        = mem_arb_pkg::N,
  parameter int LOG2SIZE = mem_arb_pkg::LOG2SIZE,
  parameter int SIZE     = 1 << LOG2SIZE
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  stateT        state, nextState;
  logic         lastGrant;
  logic         latPort, latWe;
  logic [N-1:0] latAddr, latWdata;
  logic         grantValid, grantId;
  logic         accept;
  logic         inBounds;

  rr_arbiter2 uPick (
    .req        ({bus.req_1, bus.req_0}),
    .last_grant (lastGrant),
    .grant_valid(grantValid),
    .grant_id   (grantId)
  );

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  assign inBounds = (latAddr < N'(SIZE));
`else
  assign inBounds = 1'b1;
`endif

  // Gated by reset so no accept pulse leaks out while the block is held.
  assign accept    = (state == IDLE) && grantValid && !reset;
  assign bus.ack_0 = accept && (grantId == PORT_CPU);
  assign bus.ack_1 = accept && (grantId == PORT_DMA);

  // Strobes decode only registered state, and state clears asynchronously,
  // so reset pulls mem_wr low immediately.
  assign bus.mem_addr = latAddr;
  assign bus.mem_din  = latWdata;
  assign bus.mem_rd   = (state == ISSUE) && !latWe && inBounds;
  assign bus.mem_wr   = (state == ISSUE) &&  latWe && inBounds;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = ISSUE;
      ISSUE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lastGrant   <= PORT_DMA;
      latPort     <= PORT_CPU;
      latWe       <= 1'b0;
      latAddr     <= '0;
      latWdata    <= '0;
      bus.rsp_0   <= 1'b0;
      bus.rsp_1   <= 1'b0;
      bus.rdata_0 <= '0;
      bus.rdata_1 <= '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      bus.err_0   <= 1'b0;
      bus.err_1   <= 1'b0;
`endif
    end else begin
      state     <= nextState;
      bus.rsp_0 <= 1'b0;
      bus.rsp_1 <= 1'b0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      bus.err_0 <= 1'b0;
      bus.err_1 <= 1'b0;
`endif
      if (accept) begin
        latPort   <= grantId;
        latWe     <= grantId ? bus.we_1    : bus.we_0;
        latAddr   <= grantId ? bus.addr_1  : bus.addr_0;
        latWdata  <= grantId ? bus.wdata_1 : bus.wdata_0;
        lastGrant <= grantId;
      end
      if (state == ISSUE) begin
        if (latPort == PORT_CPU) begin
          bus.rsp_0 <= 1'b1;
          if (!latWe) bus.rdata_0 <= inBounds ? bus.mem_dout : '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
          bus.err_0 <= !inBounds;
`endif
        end else begin
          bus.rsp_1 <= 1'b1;
          if (!latWe) bus.rdata_1 <= inBounds ? bus.mem_dout : '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
          bus.err_1 <= !inBounds;
`endif
        end
      end
    end
  end
endmodule
